// File: rtl/acquire_rr_lock_arbiter_pkg.sv
// Shared Acquire-channel definitions: packed field layout, a_type encodings
// and the width helper used by the arbiter and its round-robin picker.
package acquire_pkg;

  localparam int ACQ_W     = 183;
  localparam int ACQ_BEATS = 4;

  // Field layout, LSB offsets (addr_block sits at the MSB end)
  localparam int DATA_LSB    = 0;
  localparam int DATA_W      = 128;
  localparam int UNION_LSB   = 128;
  localparam int UNION_W     = 17;
  localparam int ATYPE_LSB   = 145;
  localparam int ATYPE_W     = 3;
  localparam int BUILTIN_BIT = 148;
  localparam int BEAT_LSB    = 149;
  localparam int BEAT_W      = 2;
  localparam int XACT_LSB    = 151;
  localparam int XACT_W      = 6;
  localparam int BLOCK_LSB   = 157;
  localparam int BLOCK_W     = 26;

  localparam logic [ATYPE_W-1:0] GET       = 3'b000;
  localparam logic [ATYPE_W-1:0] PUT_BLOCK = 3'b011;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index width that stays at least 1 bit for degenerate sizes
  function automatic int clog2c(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acquire_rr_lock_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, modulo N.
// When nothing is requested, idx points at ptr+1 and found is low.
module rr_pick
  import acquire_pkg::*;
#(
  parameter  int N  = 3,
  localparam int IW = clog2c(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  oh,
  output logic [IW-1:0] idx,
  output logic          found
);

  int p;
  int j;

  always_comb begin
    p     = int'(ptr);
    j     = 0;
    idx   = IW'((p + 1) % N);
    found = 1'b0;
    oh    = '0;
    // Scan farthest-first so the nearest hit after ptr is the one that sticks
    for (int k = N; k >= 1; k--) begin
      j = (p + k) % N;
      if (req[j]) begin
        idx   = IW'(j);
        found = 1'b1;
      end
    end
    if (found) oh[idx] = 1'b1;
  end

endmodule

// File: rtl/acquire_rr_lock_arbiter.sv
// N-way round-robin Acquire arbiter: locks the grant across PutBlock beats and
// throttles each source by its count of Grant-outstanding transactions.
module acquire_rr_lock_arbiter
  import acquire_pkg::*;
#(
  parameter  int N       = 3,
  parameter  int MAX_OUT = 2,
  parameter  int BEATS   = ACQ_BEATS,
  parameter  int W       = ACQ_W,
  localparam int IW      = clog2c(N),
  localparam int CW      = clog2c(MAX_OUT + 1),
  localparam int BW      = clog2c(BEATS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    io_in_valid,
  output logic [N-1:0]    io_in_ready,
  input  logic [N*W-1:0]  io_in_bits,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [W-1:0]    io_out_bits,
  output logic [IW-1:0]   io_chosen,
  input  logic            io_gnt_done_valid,
  input  logic [IW-1:0]   io_gnt_done_src,
  output logic            io_err
);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         lock_idx, rr_ptr, chosen, pick_idx;
  logic [BW-1:0]         beat_cnt;
  logic [N-1:0][CW-1:0]  out_cnt;
  logic [N-1:0]          eligible, pick_oh, dec;
  logic                  pick_found, locked, fire, multibeat, done_ok, err;
  logic [W-1:0]          sel_bits;

  for (genvar i = 0; i < N; i++) begin : g_elig
    assign eligible[i] = io_in_valid[i] && (out_cnt[i] < CW'(MAX_OUT));
  end

  rr_pick #(.N(N)) u_pick (
    .req   (eligible),
    .ptr   (rr_ptr),
    .oh    (pick_oh),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign locked    = (state_q == ARB_LOCKED);
  assign sel_bits  = io_in_bits[int'(chosen)*W +: W];
  assign multibeat = sel_bits[BUILTIN_BIT] && (sel_bits[ATYPE_LSB +: ATYPE_W] == PUT_BLOCK);
  assign fire      = io_out_valid && io_out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (fire && multibeat && BEATS > 1) state_d = ARB_LOCKED;
      ARB_LOCKED: if (fire && beat_cnt == BW'(BEATS - 1)) state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // Outputs: the grant is fully combinational, nothing on the data path is registered
  always_comb begin
    chosen       = locked ? lock_idx : pick_idx;
    io_out_valid = locked ? io_in_valid[lock_idx] : pick_found;
    for (int i = 0; i < N; i++)
      io_in_ready[i] = io_out_ready && (locked ? (lock_idx == IW'(i)) : pick_oh[i]);
  end

  assign io_out_bits = sel_bits;
  assign io_chosen   = chosen;
  assign io_err      = err;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_idx <= '0;
      beat_cnt <= '0;
      rr_ptr   <= IW'(N - 1);
    end else if (fire) begin
      if (!locked) begin
        rr_ptr <= chosen;
        if (multibeat && BEATS > 1) begin
          lock_idx <= chosen;
          beat_cnt <= BW'(1);
        end
      end else if (beat_cnt == BW'(BEATS - 1)) begin
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + BW'(1);
      end
    end
  end

  // Out-of-range sources have no counter and are treated as zero outstanding
  always_comb begin
    done_ok = 1'b0;
    dec     = '0;
    for (int i = 0; i < N; i++) begin
      if (io_gnt_done_valid && io_gnt_done_src == IW'(i) && out_cnt[i] != '0) begin
        dec[i]  = 1'b1;
        done_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                               err <= 1'b0;
    else if (io_gnt_done_valid && !done_ok)  err <= 1'b1;
  end

  for (genvar i = 0; i < N; i++) begin : g_cnt
    logic inc;
    assign inc = fire && !locked && (chosen == IW'(i));

    always_ff @(posedge clk) begin
      if (reset)
        out_cnt[i] <= '0;
      else if (inc && !dec[i] && out_cnt[i] != CW'(MAX_OUT))
        out_cnt[i] <= out_cnt[i] + CW'(1);
      else if (dec[i] && !inc)
        out_cnt[i] <= out_cnt[i] - CW'(1);
    end
  end

endmodule

// File: tb/tb_acquire_rr_lock_arbiter.sv
// Scenario bench for acquire_rr_lock_arbiter: expected grants are queued as
// stimulus is planned and popped on every observed outer fire.
module tb_acquire_rr_lock_arbiter;
  import acquire_pkg::*;

  localparam int N  = 3;
  localparam int W  = ACQ_W;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid, in_ready;
  logic [N*W-1:0]  in_bits;
  logic            out_valid, out_ready;
  logic [W-1:0]    out_bits;
  logic [IW-1:0]   chosen;
  logic            gd_valid;
  logic [IW-1:0]   gd_src;
  logic            err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {int idx; int beat;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  acquire_rr_lock_arbiter #(.N(N), .MAX_OUT(2), .BEATS(4), .W(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .io_in_valid       (in_valid),
    .io_in_ready       (in_ready),
    .io_in_bits        (in_bits),
    .io_out_valid      (out_valid),
    .io_out_ready      (out_ready),
    .io_out_bits       (out_bits),
    .io_chosen         (chosen),
    .io_gnt_done_valid (gd_valid),
    .io_gnt_done_src   (gd_src),
    .io_err            (err)
  );

  function automatic logic [W-1:0] mk(input int id, input int beat, input bit put);
    logic [W-1:0] b;
    b = '0;
    b[BLOCK_LSB +: BLOCK_W]  = 26'(id + 'h40);
    b[XACT_LSB +: XACT_W]    = 6'(id);
    b[BEAT_LSB +: BEAT_W]    = 2'(beat);
    b[BUILTIN_BIT]           = 1'b1;
    b[ATYPE_LSB +: ATYPE_W]  = put ? PUT_BLOCK : GET;
    b[DATA_LSB +: DATA_W]    = {4{32'(id * 1000 + beat)}};
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = '0;
    gd_valid  = 1'b0;
    gd_src    = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_bits[i*W +: W] = mk(i, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
    n_checks++;
    if (in_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b want 000", in_ready); end
    n_checks++;
    if (chosen !== 2'd0) begin n_fail++; $display("FAIL reset_chosen_idle: got %0d want 0", chosen); end
    out_ready = 1'b0;
    in_valid  = 3'b110;
    #1;
    n_checks++;
    if (chosen !== 2'd1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_eligible: chosen %0d valid %0b want 1/1", chosen, out_valid);
    end
    in_valid  = '0;
    out_ready = 1'b1;
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) sb.push_back('{idx: i, beat: 0});
    in_valid = 3'b111;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rr_extra_fire: chosen %0d, want no fire", chosen);
        end else begin
          e = sb.pop_front();
          if (chosen !== IW'(e.idx) || out_bits[BLOCK_LSB +: BLOCK_W] !== 26'(e.idx + 'h40)) begin
            n_fail++; $display("FAIL rr_grant: chosen %0d want %0d", chosen, e.idx);
          end
          n_checks++;
          if (in_ready !== (3'(1) << e.idx)) begin
            n_fail++; $display("FAIL rr_ready: got %b want %b", in_ready, 3'(1) << e.idx);
          end
        end
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL rr_missing: %0d grants left, want 0", sb.size()); end
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 3'b000) begin
      n_fail++; $display("FAIL rr_throttled: valid %0b ready %b want 0/000", out_valid, in_ready);
    end
  endtask

  task automatic test_putblock();
    exp_t e;
    bit f;
    int fc;
    int b1;
    do_reset();
    b1 = 0;
    in_bits[W +: W] = mk(1, 0, 1'b1);
    sb.push_back('{idx: 0, beat: 0});
    for (int b = 0; b < 4; b++) sb.push_back('{idx: 1, beat: b});
    sb.push_back('{idx: 0, beat: 0});
    in_valid = 3'b011;
    for (int c = 0; c < 14; c++) begin
      #1;
      f  = out_valid && out_ready;
      fc = int'(chosen);
      if (f) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL pb_extra_fire: chosen %0d, want no fire", chosen);
        end else begin
          e = sb.pop_front();
          if (chosen !== IW'(e.idx) || out_bits[BEAT_LSB +: BEAT_W] !== 2'(e.beat)) begin
            n_fail++;
            $display("FAIL pb_grant: chosen %0d beat %0d want %0d beat %0d",
                     chosen, out_bits[BEAT_LSB +: BEAT_W], e.idx, e.beat);
          end
        end
      end
      @(negedge clk);
      if (f && fc == 1) begin
        b1++;
        if (b1 == 4) in_valid[1] = 1'b0;
        else         in_bits[W +: W] = mk(1, b1, 1'b1);
      end
    end
    #1;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL pb_missing: %0d grants left, want 0", sb.size()); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pb_end_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_throttle();
    exp_t e;
    do_reset();
    in_valid = 3'b100;
    sb.push_back('{idx: 2, beat: 0});
    sb.push_back('{idx: 2, beat: 0});
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL thr_extra_fire: chosen %0d, want no fire", chosen);
        end else begin
          e = sb.pop_front();
          if (chosen !== IW'(e.idx)) begin n_fail++; $display("FAIL thr_grant: chosen %0d want %0d", chosen, e.idx); end
        end
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready[2] !== 1'b0) begin
      n_fail++; $display("FAIL thr_blocked: valid %0b ready2 %0b want 0/0", out_valid, in_ready[2]);
    end
    gd_valid = 1'b1;
    gd_src   = 2'd2;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL thr_same_cycle: valid %0b want 0", out_valid); end
    @(negedge clk);
    gd_valid = 1'b0;
    sb.push_back('{idx: 2, beat: 0});
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL thr_extra_refire: chosen %0d, want no fire", chosen);
        end else begin
          e = sb.pop_front();
          if (chosen !== IW'(e.idx)) begin n_fail++; $display("FAIL thr_refire: chosen %0d want %0d", chosen, e.idx); end
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL thr_missing: %0d grants left, want 0", sb.size()); end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    do_reset();
    in_valid = 3'b001;
    // One fire before, one coincident with the retire, one more to reach the cap
    for (int k = 0; k < 3; k++) sb.push_back('{idx: 0, beat: 0});
    for (int c = 0; c < 7; c++) begin
      if (c == 1) begin gd_valid = 1'b1; gd_src = 2'd0; end
      else        gd_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL sc_extra_fire: chosen %0d, want no fire", chosen);
        end else begin
          e = sb.pop_front();
          if (chosen !== IW'(e.idx)) begin n_fail++; $display("FAIL sc_grant: chosen %0d want %0d", chosen, e.idx); end
        end
      end
      @(negedge clk);
    end
    gd_valid = 1'b0;
    #1;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sc_missing: %0d grants left, want 0", sb.size()); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sc_capped: valid %0b want 0", out_valid); end
  endtask

  task automatic test_err();
    do_reset();
    #1;
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_init: got %0b want 0", err); end
    gd_valid = 1'b1;
    gd_src   = 2'd1;
    @(negedge clk);
    gd_valid = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %0b want 1", err); end
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0b want 1", err); end
    do_reset();
    #1;
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %0b want 0", err); end
  endtask

  task automatic test_reset_midlock();
    exp_t e;
    bit f;
    int b1;
    do_reset();
    b1 = 0;
    in_bits[W +: W] = mk(1, 0, 1'b1);
    in_valid = 3'b010;
    for (int b = 0; b < 3; b++) sb.push_back('{idx: 1, beat: b});
    for (int c = 0; c < 3; c++) begin
      #1;
      f = out_valid && out_ready;
      if (f) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL ml_extra_fire: chosen %0d, want no fire", chosen);
        end else begin
          e = sb.pop_front();
          if (chosen !== IW'(e.idx) || out_bits[BEAT_LSB +: BEAT_W] !== 2'(e.beat)) begin
            n_fail++; $display("FAIL ml_grant: chosen %0d want %0d beat %0d", chosen, e.idx, e.beat);
          end
        end
      end
      @(negedge clk);
      if (f) begin b1++; in_bits[W +: W] = mk(1, b1, 1'b1); end
    end
    out_ready = 1'b0;
    in_valid  = 3'b011;
    #1;
    n_checks++;
    if (chosen !== 2'd1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL ml_lock_held: chosen %0d valid %0b want 1/1", chosen, out_valid);
    end
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (chosen !== 2'd0 || out_valid !== 1'b1 || out_bits[BLOCK_LSB +: BLOCK_W] !== 26'h40) begin
      n_fail++; $display("FAIL ml_after_reset: chosen %0d valid %0b want 0/1", chosen, out_valid);
    end
    n_checks++;
    if (in_ready !== 3'b001) begin n_fail++; $display("FAIL ml_ready: got %b want 001", in_ready); end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL ml_missing: %0d grants left, want 0", sb.size()); end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_bits   = '0;
    out_ready = 1'b0;
    gd_valid  = 1'b0;
    gd_src    = '0;
    test_reset();
    test_round_robin();
    test_putblock();
    test_throttle();
    test_same_cycle();
    test_err();
    test_reset_midlock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
